// File: rtl/sdram_pkg.sv
// Shared types for the SDR SDRAM burst controller: FSM states, command encodings
// in {cke, cs_n, ras_n, cas_n, we_n} order, and the mode-register word.
package sdram_pkg;

   typedef enum logic [3:0] {
      S_INIT_WAIT,
      S_INIT_PRE,
      S_INIT_REF1,
      S_INIT_REF2,
      S_INIT_MRS,
      S_IDLE,
      S_REF,
      S_ACT,
      S_WR,
      S_RD
   } state_e;

   localparam logic [4:0] CMD_NOP   = 5'b10111;
   localparam logic [4:0] CMD_PALL  = 5'b10010;
   localparam logic [4:0] CMD_REF   = 5'b10001;
   localparam logic [4:0] CMD_MRS   = 5'b10000;
   localparam logic [4:0] CMD_ACT   = 5'b10011;
   localparam logic [4:0] CMD_READ  = 5'b10101;
   localparam logic [4:0] CMD_WRITE = 5'b10100;

   // Sequential bursts, programmed burst length and CAS latency, write-burst enabled.
   function automatic logic [15:0] mode_word(input int burst_len, input int cas_latency);
      logic [15:0] w;
      w = '0;
      case (burst_len)
         2:       w[2:0] = 3'd1;
         4:       w[2:0] = 3'd2;
         8:       w[2:0] = 3'd3;
         default: w[2:0] = 3'd0;
      endcase
      w[6:4] = 3'(cas_latency);
      return w;
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer; raises a sticky pending flag each interval
// until the controller clears it by issuing REF.
module sdram_refresh_timer
   import sdram_pkg::*;
#(
   parameter int REF_INTERVAL = 519
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic pending_o
);

   localparam int CNT_W = $clog2(REF_INTERVAL + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;
   logic             tc;

   assign tc        = (cnt_q == '0);
   assign pending_o = pending_q;

   // A new interval elapsing wins over a same-cycle clear; a second one saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= RELOAD;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= tc ? RELOAD : cnt_q - CNT_W'(1);
         pending_q <= tc | (pending_q & ~clear_i);
      end
   end

endmodule

// File: rtl/sdram_burst_controller.sv
// SDR SDRAM controller: power-up init, auto-precharged read/write bursts and
// periodic auto-refresh behind a valid/ready host command port.
//
// state       | meaning
// S_INIT_WAIT | power-up NOPs, then PALL
// S_INIT_PRE  | tRP after PALL, then first REF
// S_INIT_REF1 | tRFC after first REF, then second REF
// S_INIT_REF2 | tRFC after second REF, then MRS
// S_INIT_MRS  | tMRD after MRS, then IDLE
// S_IDLE      | refresh or accept host command
// S_REF       | tRFC after REF
// S_ACT       | tRCD after ACT, then READ/WRITE
// S_WR        | write beats plus tWR+tRP recovery
// S_RD        | CAS latency, read beats plus tRP
module sdram_burst_controller
   import sdram_pkg::*;
#(
   parameter int ROW_WIDTH     = 13,
   parameter int COL_WIDTH     = 9,
   parameter int BANK_WIDTH    = 2,
   parameter int DATA_WIDTH    = 16,
   parameter int CAS_LATENCY   = 3,
   parameter int BURST_LEN     = 4,
   parameter int CLK_FREQUENCY = 133,
   parameter int REFRESH_TIME  = 32,
   parameter int REFRESH_COUNT = 8192,
   parameter int T_RCD         = 2,
   parameter int T_RP          = 2,
   parameter int T_RFC         = 8,
   parameter int T_MRD         = 2,
   parameter int T_WR          = 2,
   parameter int INIT_WAIT     = 13300,
   localparam int HADDR_WIDTH  = BANK_WIDTH + ROW_WIDTH + COL_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [HADDR_WIDTH-1:0]  cmd_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    init_done,
   output logic [ROW_WIDTH-1:0]    addr,
   output logic [BANK_WIDTH-1:0]   bank_addr,
   output logic [DATA_WIDTH-1:0]   data_out,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    data_oe,
   output logic                    clock_enable,
   output logic                    cs_n,
   output logic                    ras_n,
   output logic                    cas_n,
   output logic                    we_n,
   output logic [DATA_WIDTH/8-1:0] data_mask
);

   localparam int REF_INTERVAL = CLK_FREQUENCY * 1000 * REFRESH_TIME / REFRESH_COUNT;
   localparam int TMR_W   = $clog2(INIT_WAIT + T_RFC + T_MRD + T_RP + T_WR + T_RCD
                                   + CAS_LATENCY + BURST_LEN + 1);
   localparam int WCNT_W  = $clog2(BURST_LEN + 1);
   localparam int RD_SR_W = CAS_LATENCY + BURST_LEN;
   localparam logic [RD_SR_W-1:0]   RD_SR_INIT = {{BURST_LEN{1'b1}}, {CAS_LATENCY{1'b0}}};
   localparam logic [15:0]          MODE_FULL  = mode_word(BURST_LEN, CAS_LATENCY);
   localparam logic [ROW_WIDTH-1:0] MODE_ADDR  = MODE_FULL[ROW_WIDTH-1:0];
   localparam logic [ROW_WIDTH-1:0] A10        = ROW_WIDTH'(1 << 10);

   state_e                  state_q;
   logic [TMR_W-1:0]        timer_q;
   logic [4:0]              cmd_q;
   logic [ROW_WIDTH-1:0]    addr_q;
   logic [BANK_WIDTH-1:0]   ba_q;
   logic [COL_WIDTH-1:0]    col_q;
   logic                    we_q;
   logic [DATA_WIDTH-1:0]   data_out_q;
   logic                    data_oe_q;
   logic [DATA_WIDTH/8-1:0] data_mask_q;
   logic                    wr_rdy_q;
   logic [WCNT_W-1:0]       wcnt_q;
   logic [RD_SR_W-1:0]      rd_sr_q;
   logic                    rd_valid_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    init_done_q;
   logic                    ref_pending;
   logic                    ref_clear;

   sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (ref_clear),
      .pending_o (ref_pending)
   );

   assign cmd_ready = (state_q == S_IDLE) & ~ref_pending;
   assign ref_clear = (state_q == S_IDLE) & ref_pending;

   assign {clock_enable, cs_n, ras_n, cas_n, we_n} = cmd_q;
   assign addr          = addr_q;
   assign bank_addr     = ba_q;
   assign data_out      = data_out_q;
   assign data_oe       = data_oe_q;
   assign data_mask     = data_mask_q;
   assign wr_data_ready = wr_rdy_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign init_done     = init_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT_WAIT;
         timer_q     <= TMR_W'(INIT_WAIT);
         cmd_q       <= CMD_NOP;
         addr_q      <= '0;
         ba_q        <= '0;
         col_q       <= '0;
         we_q        <= 1'b0;
         data_out_q  <= '0;
         data_oe_q   <= 1'b0;
         data_mask_q <= '1;
         wr_rdy_q    <= 1'b0;
         wcnt_q      <= '0;
         rd_sr_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         cmd_q <= CMD_NOP;
         if (timer_q != '0) timer_q <= timer_q - TMR_W'(1);

         // Read capture window: bit 0 of the shift register marks a beat on data_in.
         rd_sr_q    <= rd_sr_q >> 1;
         rd_valid_q <= rd_sr_q[0];
         if (rd_sr_q[0]) rd_data_q <= data_in;

         data_oe_q   <= wr_rdy_q;
         data_mask_q <= wr_rdy_q ? '0 : '1;
         if (wr_rdy_q) begin
            data_out_q <= wr_data;
            if (wcnt_q == '0) wr_rdy_q <= 1'b0;
            else              wcnt_q   <= wcnt_q - WCNT_W'(1);
         end

         case (state_q)
            S_INIT_WAIT: if (timer_q == '0) begin
               cmd_q   <= CMD_PALL;
               addr_q  <= A10;
               timer_q <= TMR_W'(T_RP);
               state_q <= S_INIT_PRE;
            end
            S_INIT_PRE: if (timer_q == '0) begin
               cmd_q   <= CMD_REF;
               timer_q <= TMR_W'(T_RFC);
               state_q <= S_INIT_REF1;
            end
            S_INIT_REF1: if (timer_q == '0) begin
               cmd_q   <= CMD_REF;
               timer_q <= TMR_W'(T_RFC);
               state_q <= S_INIT_REF2;
            end
            S_INIT_REF2: if (timer_q == '0) begin
               cmd_q   <= CMD_MRS;
               addr_q  <= MODE_ADDR;
               timer_q <= TMR_W'(T_MRD);
               state_q <= S_INIT_MRS;
            end
            S_INIT_MRS: if (timer_q == '0) begin
               init_done_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            S_IDLE: begin
               if (ref_pending) begin
                  cmd_q   <= CMD_REF;
                  timer_q <= TMR_W'(T_RFC);
                  state_q <= S_REF;
               end else if (cmd_valid) begin
                  cmd_q   <= CMD_ACT;
                  ba_q    <= cmd_addr[HADDR_WIDTH-1 -: BANK_WIDTH];
                  addr_q  <= cmd_addr[COL_WIDTH +: ROW_WIDTH];
                  col_q   <= cmd_addr[COL_WIDTH-1:0];
                  we_q    <= cmd_we;
                  timer_q <= TMR_W'(T_RCD - 1);
                  state_q <= S_ACT;
                  // With tRCD of one the first beat is due during the ACT cycle itself.
                  if (cmd_we && T_RCD == 1) begin
                     wr_rdy_q <= 1'b1;
                     wcnt_q   <= WCNT_W'(BURST_LEN - 1);
                  end
               end
            end
            S_ACT: begin
               if (we_q && timer_q == TMR_W'(1)) begin
                  wr_rdy_q <= 1'b1;
                  wcnt_q   <= WCNT_W'(BURST_LEN - 1);
               end
               if (timer_q == '0) begin
                  addr_q <= ROW_WIDTH'(col_q) | A10;
                  if (we_q) begin
                     cmd_q   <= CMD_WRITE;
                     timer_q <= TMR_W'(BURST_LEN - 1 + T_WR + T_RP);
                     state_q <= S_WR;
                  end else begin
                     cmd_q   <= CMD_READ;
                     rd_sr_q <= RD_SR_INIT;
                     timer_q <= TMR_W'(CAS_LATENCY + BURST_LEN - 1 + T_RP);
                     state_q <= S_RD;
                  end
               end
            end
            S_WR, S_RD, S_REF: if (timer_q == '0) state_q <= S_IDLE;
            default: state_q <= S_INIT_WAIT;
         endcase
      end
   end

endmodule
